// File: rtl/cim_scanner.sv
// cim_scanner: address sequencer for the 3-to-8 one-hot decoder in the
// multiplexed display path. Each digit slot is PRESC cycles long: BLANK
// blanked cycles, then PRESC-BLANK cycles with valid=1. frame_start marks
// the first cycle of every address-0 slot. All outputs are registered.
module cim_scanner #(
  parameter int PRESC  = 1000,
  parameter int BLANK  = 16,
  parameter int DIGITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       hold,
  output logic [2:0] cim,
  output logic       valid,
  output logic       frame_start
);

  localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [2:0]    CIM_LAST   = 3'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      cim_q, cim_d;
  logic            valid_q, valid_d;
  logic            fs_q, fs_d;

  logic            active;
  logic            advance;
  logic            blank_end;
  logic            slot_end;
  logic            wrap;

  // Decode of the current slot position; only meaningful while scanning.
  always_comb begin
    active    = (state_q == S_BLANK) || (state_q == S_SHOW);
    advance   = active && en && !hold;
    blank_end = (state_q == S_BLANK) && (cnt_q == BLANK_LAST);
    slot_end  = (state_q == S_SHOW) && (cnt_q == SLOT_LAST);
    wrap      = (cim_q >= CIM_LAST);
  end

  // State and slot-counter register; async reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cim_q   <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cim_q   <= cim_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
    end
  end

  // Next state and slot counter: en dominates hold, hold freezes the slot.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (en) state_d = S_BLANK;
      end
      S_BLANK, S_SHOW: begin
        if (!en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!hold) begin
          if (slot_end) begin
            state_d = S_BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (blank_end) state_d = S_SHOW;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs: address stepping, show-phase flag and frame pulse.
  always_comb begin
    cim_d   = cim_q;
    valid_d = (state_d == S_SHOW);
    fs_d    = 1'b0;
    if (state_q == S_IDLE) begin
      cim_d = '0;
      fs_d  = en;
    end else if (!active || !en) begin
      cim_d = '0;
    end else if (advance && slot_end) begin
      cim_d = wrap ? 3'd0 : cim_q + 3'd1;
      fs_d  = wrap;
    end
  end

  assign cim         = cim_q;
  assign valid       = valid_q;
  assign frame_start = fs_q;

endmodule
